dct_block_sequencer: RTL and testbench

Control block that sequences the 8x8 DCT core (`top`: `enin`, `enout`, 10-bit signed data in/out) over a continuous stream of pixel blocks. It accepts pixels over a valid/ready handshake and drives the core's load phase, including flush padding. It then waits the core's fixed compute latency and drains the 64 coefficients to a valid-qualified output stream with a coefficient index. It sits between the pixel source (line buffer / file reader) and the quantiser.

---
 rtl/dct_seq_pkg.sv | 42 ++++
 rtl/dct_seq_timer.sv | 43 ++++
 rtl/dct_block_sequencer.sv | 175 +++++++++++++++++
 tb/tb_dct_block_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_seq_pkg.sv
// ----------------------------------------------------------------------------
// dct_seq_pkg
// Shared types and constants for the DCT block sequencer.
//   seq_state_e       : sequencer FSM states
//   BLK_PIXELS, IDX_W : block size (8x8) and coefficient index width
//   TMR_W             : width of the FLUSH/WAIT down-counter
// Optional feature macro: DCT_SEQ_ZIGZAG_EN builds the raster-to-zigzag LUT
// and its lookup function.
// ----------------------------------------------------------------------------
package dct_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_WAIT,
        ST_DRAIN
    } seq_state_e;

    localparam int unsigned BLK_PIXELS = 64;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned TMR_W      = 8;

`ifdef DCT_SEQ_ZIGZAG_EN
    // Entry [raster position] = zigzag scan index of that coefficient.
    localparam logic [IDX_W-1:0] ZIGZAG_LUT [BLK_PIXELS] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };

    function automatic logic [IDX_W-1:0] raster_to_zigzag(input logic [IDX_W-1:0] pos);
        return ZIGZAG_LUT[pos];
    endfunction
`endif

endpackage

// File: rtl/dct_seq_timer.sv
// ----------------------------------------------------------------------------
// dct_seq_timer
// Loadable down-counter used for the FLUSH and WAIT durations. Loading N makes
// `zero` rise after N further cycles; the counter then holds at zero.
//   clk, rst : clock, asynchronous active-low reset
//   load     : load `value` this cycle
//   value    : count to load
//   zero     : counter is at zero
// ----------------------------------------------------------------------------
module dct_seq_timer
    import dct_seq_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dct_block_sequencer.sv
// ----------------------------------------------------------------------------
// dct_block_sequencer
// Sequences an 8x8 DCT core over a stream of pixel blocks:
// load 64 pixels (valid/ready), pad FLUSH zero beats, wait LATENCY cycles,
// then drain 64 coefficients to a valid-qualified stream with an index.
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid/in_data    : pixel stream in (raster order), in_ready out
//   core_enin/core_din  : core load strobe and data
//   core_enout          : core drain strobe
//   core_dout           : core coefficient output (valid the cycle after enout)
//   out_valid/out_data  : coefficient stream out, out_idx = coefficient index
//   blk_done            : pulse with the last coefficient of a block
//   busy                : FSM is not idle
// Optional feature macro: DCT_SEQ_ZIGZAG_EN makes out_idx the zigzag index.
// ----------------------------------------------------------------------------
module dct_block_sequencer
    import dct_seq_pkg::*;
#(
    parameter int unsigned DW      = 10,
    parameter int unsigned FLUSH   = 2,
    parameter int unsigned LATENCY = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 in_ready,
    output logic                 core_enin,
    output logic signed [DW-1:0] core_din,
    output logic                 core_enout,
    input  logic signed [DW-1:0] core_dout,
    output logic                 out_valid,
    output logic signed [DW-1:0] out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 blk_done,
    output logic                 busy
);

    localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(BLK_PIXELS - 1);
    localparam logic [TMR_W-1:0] FLUSH_LD = TMR_W'(FLUSH - 1);
    localparam logic [TMR_W-1:0] LAT_LD   = TMR_W'(LATENCY - 1);

    seq_state_e       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             core_enout_q, core_enout_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             blk_done_q, blk_done_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_value;
    logic             tmr_zero;
    logic [IDX_W-1:0] drain_idx;

    dct_seq_timer #(.W(TMR_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    assign accept = in_valid & in_ready_q;

`ifdef DCT_SEQ_ZIGZAG_EN
    assign drain_idx = raster_to_zigzag(cnt_q);
`else
    assign drain_idx = cnt_q;
`endif

    // cnt_q counts accepted beats in LOAD and drain beats in DRAIN.
    // The timer is loaded with N-1 on state entry so the state lasts N cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                    cnt_d   = IDX_W'(1);
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        tmr_load = 1'b1;
                        if (FLUSH == 0) begin
                            state_d   = ST_WAIT;
                            tmr_value = LAT_LD;
                        end else begin
                            state_d   = ST_FLUSH;
                            tmr_value = FLUSH_LD;
                        end
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (tmr_zero) begin
                    state_d   = ST_WAIT;
                    tmr_load  = 1'b1;
                    tmr_value = LAT_LD;
                end
            end
            ST_WAIT: begin
                if (tmr_zero) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs: strobes decode the next state; the output stream
    // trails core_enout by one cycle to line up with core_dout.
    always_comb begin
        in_ready_d   = (state_d == ST_IDLE) || (state_d == ST_LOAD);
        core_enout_d = (state_d == ST_DRAIN);
        busy_d       = (state_d != ST_IDLE);
        out_valid_d  = core_enout_q;
        out_idx_d    = core_enout_q ? drain_idx : '0;
        blk_done_d   = core_enout_q && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            core_enout_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            blk_done_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            core_enout_q <= core_enout_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            blk_done_q   <= blk_done_d;
            busy_q       <= busy_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign core_enin  = accept | (state_q == ST_FLUSH);
    assign core_din   = accept ? in_data : '0;
    assign core_enout = core_enout_q;
    assign out_valid  = out_valid_q;
    assign out_data   = core_dout;
    assign out_idx    = out_idx_q;
    assign blk_done   = blk_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// ----------------------------------------------------------------------------
// tb_dct_block_sequencer
// Two sequencer instances: A with FLUSH=2/LATENCY=40, B with FLUSH=0/LATENCY=1.
// The reference model tracks accepted-pixel count and the cycle of the 64th
// accept; every other expectation is a fixed offset from that cycle.
// A stand-in core returns per-block random coefficients on each enout cycle.
// ----------------------------------------------------------------------------
module tb_dct_block_sequencer;

    localparam int DW = 10;
    localparam int FA = 2;
    localparam int LA = 40;
    localparam int FB = 0;
    localparam int LB = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid_a, in_valid_b;
    logic [DW-1:0] in_data;

    logic          in_ready_a, core_enin_a, core_enout_a, out_valid_a, blk_done_a, busy_a;
    logic [DW-1:0] core_din_a, core_dout_a, out_data_a;
    logic [5:0]    out_idx_a;
    logic          in_ready_b, core_enin_b, core_enout_b, out_valid_b, blk_done_b, busy_b;
    logic [DW-1:0] core_din_b, core_dout_b, out_data_b;
    logic [5:0]    out_idx_b;

    dct_block_sequencer #(.DW(DW), .FLUSH(FA), .LATENCY(LA)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_data(in_data), .in_ready(in_ready_a),
        .core_enin(core_enin_a), .core_din(core_din_a), .core_enout(core_enout_a),
        .core_dout(core_dout_a),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_idx(out_idx_a),
        .blk_done(blk_done_a), .busy(busy_a)
    );

    dct_block_sequencer #(.DW(DW), .FLUSH(FB), .LATENCY(LB)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_data(in_data), .in_ready(in_ready_b),
        .core_enin(core_enin_b), .core_din(core_din_b), .core_enout(core_enout_b),
        .core_dout(core_dout_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_idx(out_idx_b),
        .blk_done(blk_done_b), .busy(busy_b)
    );

    // Stand-in cores: the k-th enout cycle of a block yields coef[k] next cycle.
    logic [DW-1:0] coef [64];
    int rd_a, rd_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_a <= 0;
            core_dout_a <= '0;
        end else if (core_enout_a) begin
            core_dout_a <= coef[rd_a];
            rd_a <= (rd_a + 1) % 64;
        end else begin
            core_dout_a <= '0;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_b <= 0;
            core_dout_b <= '0;
        end else if (core_enout_b) begin
            core_dout_b <= coef[rd_b];
            rd_b <= (rd_b + 1) % 64;
        end else begin
            core_dout_b <= '0;
        end
    end

    // Observed signals of the instance under test.
    int            sel;
    logic          o_ready, o_enin, o_enout, o_ov, o_done, o_busy;
    logic [DW-1:0] o_din, o_data;
    logic [5:0]    o_idx;

    always_comb begin
        if (sel == 0) begin
            o_ready = in_ready_a;  o_enin = core_enin_a; o_din = core_din_a;
            o_enout = core_enout_a; o_ov = out_valid_a; o_data = out_data_a;
            o_idx = out_idx_a;     o_done = blk_done_a;  o_busy = busy_a;
        end else begin
            o_ready = in_ready_b;  o_enin = core_enin_b; o_din = core_din_b;
            o_enout = core_enout_b; o_ov = out_valid_b; o_data = out_data_b;
            o_idx = out_idx_b;     o_done = blk_done_b;  o_busy = busy_b;
        end
    end

    // Reference model state.
    int F, L;
    int acc;          // pixels accepted in the current block
    int t_last;       // cycle of the 64th accepted pixel
    int ob_base;      // cycle of the first out_valid beat of that block
    int gcyc;
    int blocks_done;
    int zz [64];      // expected out_idx for drain beat k
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, gcyc, obs, exp);
        end
    endtask

    task automatic build_idx_map();
`ifdef DCT_SEQ_ZIGZAG_EN
        int n = 0;
        // Walk anti-diagonals, alternating direction, numbering positions.
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 1) begin
                for (int r = 0; r < 8; r++) begin
                    if (s - r >= 0 && s - r < 8) begin
                        zz[r * 8 + (s - r)] = n;
                        n++;
                    end
                end
            end else begin
                for (int r = 7; r >= 0; r--) begin
                    if (s - r >= 0 && s - r < 8) begin
                        zz[r * 8 + (s - r)] = n;
                        n++;
                    end
                end
            end
        end
`else
        for (int i = 0; i < 64; i++) zz[i] = i;
`endif
    endtask

    task automatic new_coef();
        for (int i = 0; i < 64; i++) coef[i] = DW'($urandom);
    endtask

    task automatic reset_model();
        acc = 0;
        t_last = -100000;
        ob_base = -100000;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d);
        in_data = d;
        in_valid_a = (sel == 0) ? v : 1'b0;
        in_valid_b = (sel == 1) ? v : 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(o_ready), 32'd0);
        chk({tag, "_core_enin"}, 32'(o_enin), 32'd0);
        chk({tag, "_core_din"}, 32'(o_din), 32'd0);
        chk({tag, "_core_enout"}, 32'(o_enout), 32'd0);
        chk({tag, "_out_valid"}, 32'(o_ov), 32'd0);
        chk({tag, "_out_idx"}, 32'(o_idx), 32'd0);
        chk({tag, "_blk_done"}, 32'(o_done), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    // One clock cycle: drive at posedge+1, sample/check at negedge.
    // vmode: 0 valid high, 1 alternate, 2 random, 3 idle.
    task automatic cycle(input int vmode);
        logic          v;
        logic [DW-1:0] d;
        int            rel, k;
        logic          e_ready, e_enin, e_enout, e_busy, e_ov;
        logic [DW-1:0] e_din;
        case (vmode)
            0:       v = 1'b1;
            1:       v = (gcyc % 2 == 0);
            2:       v = 1'($urandom_range(0, 1));
            default: v = 1'b0;
        endcase
        d = DW'($urandom);
        drive(v, d);
        @(negedge clk);
        // The cycle after the last drain beat is IDLE: a new block may start.
        if (acc == 64 && gcyc - t_last == F + L + 65) acc = 0;
        if (acc < 64) begin
            e_ready = 1'b1;
            e_enin  = v;
            e_din   = v ? d : '0;
            e_enout = 1'b0;
            e_busy  = (acc > 0);
        end else begin
            rel     = gcyc - t_last;
            e_ready = 1'b0;
            e_enin  = (rel <= F);
            e_din   = '0;
            e_enout = (rel > F + L);
            e_busy  = 1'b1;
        end
        k = gcyc - ob_base;
        e_ov = (k >= 0 && k < 64);
        chk("in_ready", 32'(o_ready), 32'(e_ready));
        chk("core_enin", 32'(o_enin), 32'(e_enin));
        chk("core_din", 32'(o_din), 32'(e_din));
        chk("core_enout", 32'(o_enout), 32'(e_enout));
        chk("busy", 32'(o_busy), 32'(e_busy));
        chk("out_valid", 32'(o_ov), 32'(e_ov));
        chk("blk_done", 32'(o_done), 32'(e_ov && k == 63));
        if (e_ov) begin
            chk("out_idx", 32'(o_idx), 32'(zz[k]));
            chk("out_data", 32'(o_data), 32'(coef[k]));
        end
        if (acc < 64 && v) begin
            acc++;
            if (acc == 64) begin
                t_last = gcyc;
                ob_base = gcyc + F + L + 2;
                new_coef();
            end
        end
        if (e_ov && k == 63) blocks_done++;
        @(posedge clk);
        #1;
        gcyc++;
    endtask

    task automatic run_blocks(input int n, input int vmode);
        int target, cnt;
        target = blocks_done + n;
        cnt = 0;
        while (blocks_done < target && cnt < 1000 * n) begin
            cycle(vmode);
            cnt++;
        end
        chk("blocks_complete", 32'(blocks_done >= target), 32'd1);
    endtask

    task automatic run_cycles(input int n, input int vmode);
        for (int i = 0; i < n; i++) cycle(vmode);
    endtask

    initial begin
        build_idx_map();
        for (int i = 0; i < 64; i++) coef[i] = '0;
        sel = 0;
        F = FA;
        L = LA;
        gcyc = 0;
        blocks_done = 0;
        reset_model();

        // Reset values, with a pixel offered that must not be accepted.
        rst = 1'b0;
        drive(1'b1, DW'(341));
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        drive(1'b0, '0);
        @(posedge clk);
        #1;

        // Back-to-back blocks with in_valid held high.
        run_blocks(2, 0);
        // in_valid alternating, then random gaps.
        run_blocks(2, 1);
        run_blocks(1, 2);

        // Reset asserted while waiting for the core.
        begin
            int cnt = 0;
            while (!(acc == 64 && gcyc - t_last == F + 10) && cnt < 2000) begin
                cycle(2);
                cnt++;
            end
            chk("reached_wait", 32'(acc == 64 && gcyc - t_last == F + 10), 32'd1);
        end
        #2 rst = 1'b0;
        drive(1'b1, DW'(77));
        #1;
        check_reset_outputs("reset_in_wait");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, '0);
        @(posedge clk);
        #1;
        reset_model();
        run_cycles(F + L + 70, 3);
        run_blocks(1, 2);

        // Instance B: FLUSH=0, LATENCY=1.
        drive(1'b0, '0);
        sel = 1;
        F = FB;
        L = LB;
        reset_model();
        run_cycles(2, 3);
        run_blocks(2, 0);
        run_blocks(1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
